// File: rtl/rv32v_fxp_pkg.sv
// Shared constants and types for the rv32v fixed-point narrowing datapath.
// Lane widths and saturation bounds for the vnclip/vnclipu tail.
package rv32v_fxp_pkg;

  localparam int LEN_VECTOR = 32;
  localparam int NARROW     = LEN_VECTOR / 2;

  localparam logic [NARROW-1:0] SAT_UMAX = 16'hFFFF;
  localparam logic [NARROW-1:0] SAT_SMAX = 16'h7FFF;
  localparam logic [NARROW-1:0] SAT_SMIN = 16'h8000;

  typedef struct packed {
    logic [NARROW-1:0] data;
    logic              sat;
  } narrow_res_t;

endpackage

// File: rtl/vnclip_lane_clip.sv
// Combinational narrowing of one 32-bit lane to 16 bits with signed or
// unsigned saturation.
module vnclip_lane_clip
  import rv32v_fxp_pkg::*;
(
  input  logic [LEN_VECTOR-1:0] lane,
  input  logic                  signed_mode,
  output logic [NARROW-1:0]     result,
  output logic                  sat
);

  narrow_res_t res;

  // Signed fits iff everything from the new sign bit upward is a sign copy.
  always_comb begin
    res.data = lane[NARROW-1:0];
    res.sat  = 1'b0;
    if (signed_mode) begin
      if (lane[LEN_VECTOR-1:NARROW-1] != {(LEN_VECTOR-NARROW+1){lane[LEN_VECTOR-1]}}) begin
        res.sat  = 1'b1;
        res.data = lane[LEN_VECTOR-1] ? SAT_SMIN : SAT_SMAX;
      end
    end else if (|lane[LEN_VECTOR-1:NARROW]) begin
      res.sat  = 1'b1;
      res.data = SAT_UMAX;
    end
  end

  assign result = res.data;
  assign sat    = res.sat;

endmodule

// File: rtl/vnclip_narrow_sat.sv
// Two-stage valid/ready pipeline narrowing two 32-bit lanes to 16 bits with
// saturation, plus the sticky vxsat flag for the CSR file.
module vnclip_narrow_sat
  import rv32v_fxp_pkg::narrow_res_t;
#(
  parameter int LEN_CSR    = 64,
  parameter int LEN_VECTOR = 32,
  parameter int NARROW     = LEN_VECTOR / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LEN_CSR-1:0]    in_data,
  input  logic                  in_signed,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*NARROW-1:0]   out_data,
  output logic [1:0]            out_sat,
  output logic                  out_last,
  output logic                  vxsat,
  input  logic                  vxsat_clr
);

  logic               s1_valid;
  logic [LEN_CSR-1:0] s1_data;
  logic               s1_signed;
  logic               s1_last;

  logic               s2_valid;
  logic [2*NARROW-1:0] s2_data;
  logic [1:0]         s2_sat;
  logic               s2_last;

  logic               s2_load;
  narrow_res_t        res0;
  narrow_res_t        res1;

  vnclip_lane_clip u_clip0 (
    .lane        (s1_data[LEN_VECTOR-1:0]),
    .signed_mode (s1_signed),
    .result      (res0.data),
    .sat         (res0.sat)
  );

  vnclip_lane_clip u_clip1 (
    .lane        (s1_data[LEN_CSR-1:LEN_VECTOR]),
    .signed_mode (s1_signed),
    .result      (res1.data),
    .sat         (res1.sat)
  );

  assign s2_load  = !s2_valid || (s2_valid && out_ready);
  assign in_ready = !s1_valid || s2_load;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_sat   = s2_sat;
  assign out_last  = s2_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_signed <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_sat    <= '0;
      s2_last   <= 1'b0;
      vxsat     <= 1'b0;
    end else begin
      // S2 payload only changes when a real beat moves in, so a drained
      // stage keeps its last values instead of picking up S1 garbage.
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= {res1.data, res0.data};
          s2_sat  <= {res1.sat, res0.sat};
          s2_last <= s1_last;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data   <= in_data;
          s1_signed <= in_signed;
          s1_last   <= in_last;
        end
      end
      // Set has priority over a simultaneous CSR clear.
      if (s2_valid && out_ready && |s2_sat)
        vxsat <= 1'b1;
      else if (vxsat_clr)
        vxsat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vnclip_narrow_sat.sv
// Self-checking bench for vnclip_narrow_sat: directed scenarios plus a
// randomized stream checked against an arithmetic reference model.
module tb_vnclip_narrow_sat;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_signed;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sat;
  logic        out_last;
  logic        vxsat;
  logic        vxsat_clr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  sat;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  vnclip_narrow_sat dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_last  (out_last),
    .vxsat     (vxsat),
    .vxsat_clr (vxsat_clr)
  );

  always #5 clk = ~clk;

  // Reference: numeric range check of the lane value, returns {sat, data}.
  function automatic logic [16:0] ref_lane(input logic [31:0] x, input bit s);
    longint v;
    if (s) begin
      v = longint'($signed(x));
      if (v > 32767)  return {1'b1, 16'h7FFF};
      if (v < -32768) return {1'b1, 16'h8000};
      return {1'b0, x[15:0]};
    end
    v = longint'({32'd0, x});
    if (v > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, x[15:0]};
  endfunction

  function automatic exp_t ref_beat(input logic [63:0] d, input bit s, input bit l);
    exp_t e;
    logic [16:0] r0, r1;
    r0 = ref_lane(d[31:0], s);
    r1 = ref_lane(d[63:32], s);
    e.d    = {r1[15:0], r0[15:0]};
    e.sat  = {r1[16], r0[16]};
    e.last = l;
    return e;
  endfunction

  function automatic logic [31:0] gen_lane();
    int unsigned k;
    logic [31:0] c;
    k = $urandom_range(0, 5);
    case (k)
      0: c = $urandom;
      1: c = $urandom_range(0, 32'h0001_FFFF);
      2: c = 32'hFFFF_0000 | $urandom_range(0, 32'h0000_FFFF);
      3: begin
        c = 32'h0000_7FFE + $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1) c = 32'hFFFF_7FFE + $urandom_range(0, 3);
      end
      4: c = 32'h0000_FFFE + $urandom_range(0, 3);
      default: c = $urandom_range(0, 32'h0000_7FFF);
    endcase
    return c;
  endfunction

  task automatic send_beat(input logic [63:0] d, input bit s, input bit l, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    in_last   = l;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clr_vxsat();
    @(negedge clk);
    vxsat_clr = 1'b1;
    @(negedge clk);
    vxsat_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || vxsat !== 1'b0 || out_data !== 32'd0 || out_sat !== 2'b00 || out_last !== 1'b0)
      $display("FAIL reset_outputs: got valid=%b vxsat=%b data=%h sat=%b last=%b, want all zero",
               out_valid, vxsat, out_data, out_sat, out_last);
    if (out_valid !== 1'b0 || vxsat !== 1'b0 || out_data !== 32'd0 || out_sat !== 2'b00 || out_last !== 1'b0)
      n_err++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
      n_err++;
    end
  endtask

  task automatic test_unsigned();
    bit ok;
    out_ready = 1'b1;
    send_beat({32'h0000_1234, 32'h0001_0000}, 1'b0, 1'b0, ok);
    n_cmp++;
    if (!ok) begin $display("FAIL uns_accept: beat not accepted, want accepted"); n_err++; end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin $display("FAIL uns_latency_early: out_valid=%b, want 0", out_valid); n_err++; end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_FFFF || out_sat !== 2'b01) begin
      $display("FAIL uns_result: valid=%b data=%h sat=%b, want 1 1234ffff 01", out_valid, out_data, out_sat);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (vxsat !== 1'b1) begin $display("FAIL uns_vxsat: got %b, want 1", vxsat); n_err++; end
  endtask

  task automatic test_signed_bounds();
    bit ok;
    clr_vxsat();
    out_ready = 1'b1;
    send_beat({32'hFFFF_8000, 32'h0000_8000}, 1'b1, 1'b0, ok);
    wait_out(ok);
    n_cmp++;
    if (!ok || out_data !== 32'h8000_7FFF || out_sat !== 2'b01) begin
      $display("FAIL sgn_bounds_a: valid=%b data=%h sat=%b, want 1 80007fff 01", ok, out_data, out_sat);
      n_err++;
    end
    send_beat({32'hFFFF_7FFF, 32'h0000_7FFF}, 1'b1, 1'b0, ok);
    wait_out(ok);
    n_cmp++;
    if (!ok || out_data !== 32'h8000_7FFF || out_sat !== 2'b10) begin
      $display("FAIL sgn_bounds_b: valid=%b data=%h sat=%b, want 1 80007fff 10", ok, out_data, out_sat);
      n_err++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] bp[6];
    exp_t        e;
    int          sent = 0;
    int          got = 0;
    bit          stalled = 1'b0;
    logic [31:0] held_d;
    logic [1:0]  held_s;
    logic        held_l;
    for (int k = 0; k < 6; k++)
      bp[k] = {32'(k + 1), 32'((k + 1) << 14)};
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < 6) begin
        in_valid  = 1'b1;
        in_data   = bp[sent];
        in_signed = 1'b0;
        in_last   = (sent == 5);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (cyc == 3) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready_drop: got %b, want 0", in_ready); n_err++; end
      end
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_sat !== held_s || out_last !== held_l) begin
          $display("FAIL bp_stall_hold: data=%h sat=%b last=%b, want %h %b %b", out_data, out_sat, out_last,
                   held_d, held_s, held_l);
          n_err++;
        end
      end
      if (out_valid && out_ready) begin
        e = ref_beat(bp[got], 1'b0, got == 5);
        n_cmp++;
        if (out_data !== e.d || out_sat !== e.sat || out_last !== e.last) begin
          $display("FAIL bp_beat%0d: data=%h sat=%b last=%b, want %h %b %b", got, out_data, out_sat, out_last,
                   e.d, e.sat, e.last);
          n_err++;
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_s  = out_sat;
      held_l  = out_last;
      if (in_valid && in_ready) sent++;
      if (got == 6) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (got != 6) begin $display("FAIL bp_count: delivered %0d, want 6", got); n_err++; end
  endtask

  task automatic test_vxsat_race();
    bit ok;
    clr_vxsat();
    out_ready = 1'b0;
    send_beat({32'h0, 32'h0002_0000}, 1'b0, 1'b0, ok);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || vxsat !== 1'b0) begin
      $display("FAIL race_setup: valid=%b vxsat=%b, want 1 0", out_valid, vxsat);
      n_err++;
    end
    out_ready = 1'b1;
    vxsat_clr = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (vxsat !== 1'b1) begin $display("FAIL race_set_wins: vxsat=%b, want 1", vxsat); n_err++; end
    @(negedge clk);
    vxsat_clr = 1'b0;
    #1;
    n_cmp++;
    if (vxsat !== 1'b0) begin $display("FAIL race_clr_alone: vxsat=%b, want 0", vxsat); n_err++; end
  endtask

  task automatic test_midstream_reset();
    bit ok;
    int extra = 0;
    out_ready = 1'b1;
    send_beat({32'h0, 32'hFFFF_FFFF}, 1'b0, 1'b0, ok);
    wait_out(ok);
    @(negedge clk);
    n_cmp++;
    if (vxsat !== 1'b1) begin $display("FAIL mrst_vxsat_pre: vxsat=%b, want 1", vxsat); n_err++; end
    out_ready = 1'b0;
    send_beat({32'h0003_0000, 32'h0000_0011}, 1'b0, 1'b1, ok);
    send_beat({32'h0000_0022, 32'h0004_0000}, 1'b0, 1'b1, ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || vxsat !== 1'b0 || out_data !== 32'd0 || out_sat !== 2'b00 || out_last !== 1'b0) begin
      $display("FAIL mrst_clear: valid=%b vxsat=%b data=%h sat=%b last=%b, want all zero",
               out_valid, vxsat, out_data, out_sat, out_last);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin $display("FAIL mrst_in_ready: got %b, want 1", in_ready); n_err++; end
    out_ready = 1'b1;
    send_beat({32'h0, 32'h0000_0042}, 1'b0, 1'b0, ok);
    wait_out(ok);
    n_cmp++;
    if (!ok || out_data !== 32'h0000_0042 || out_sat !== 2'b00 || out_last !== 1'b0) begin
      $display("FAIL mrst_new_beat: valid=%b data=%h sat=%b last=%b, want 1 00000042 00 0",
               ok, out_data, out_sat, out_last);
      n_err++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    n_cmp++;
    if (extra != 0) begin $display("FAIL mrst_stale: %0d extra output cycles, want 0", extra); n_err++; end
  endtask

  task automatic test_random();
    localparam int NBEATS = 10000;
    int          sent = 0;
    int          cycles = 0;
    bit          m_vxsat = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] held_d;
    logic [1:0]  held_s;
    logic        held_l;
    exp_t        e;
    clr_vxsat();
    exp_q.delete();
    while ((sent < NBEATS || exp_q.size() != 0) && cycles < 60000) begin
      cycles++;
      @(negedge clk);
      in_valid  = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
      in_data   = {gen_lane(), gen_lane()};
      in_signed = $urandom_range(0, 1);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      vxsat_clr = ($urandom_range(0, 15) == 0);
      #1;
      n_cmp++;
      if (vxsat !== m_vxsat) begin
        $display("FAIL rnd_vxsat: cycle %0d got %b, want %b", cycles, vxsat, m_vxsat);
        n_err++;
      end
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_sat !== held_s || out_last !== held_l) begin
          $display("FAIL rnd_stall_hold: cycle %0d data=%h sat=%b, want %h %b", cycles, out_data, out_sat,
                   held_d, held_s);
          n_err++;
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_spurious: cycle %0d output %h with nothing expected", cycles, out_data);
          n_err++;
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_sat !== e.sat || out_last !== e.last) begin
            $display("FAIL rnd_beat: cycle %0d data=%h sat=%b last=%b, want %h %b %b", cycles,
                     out_data, out_sat, out_last, e.d, e.sat, e.last);
            n_err++;
          end
          if (e.sat != 2'b00) m_vxsat = 1'b1;
          else if (vxsat_clr) m_vxsat = 1'b0;
        end
      end else if (vxsat_clr) begin
        m_vxsat = 1'b0;
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_s  = out_sat;
      held_l  = out_last;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_beat(in_data, in_signed, in_last));
        sent++;
        n_cmp++;
        if (exp_q.size() > 2) begin
          $display("FAIL rnd_inflight: %0d beats in flight, want at most 2", exp_q.size());
          n_err++;
        end
      end
    end
    in_valid  = 1'b0;
    vxsat_clr = 1'b0;
    n_cmp++;
    if (sent != NBEATS || exp_q.size() != 0) begin
      $display("FAIL rnd_timeout: sent %0d pending %0d, want %0d and 0", sent, exp_q.size(), NBEATS);
      n_err++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    vxsat_clr = 1'b0;
    test_reset();
    test_unsigned();
    test_signed_bounds();
    test_backpressure();
    test_vxsat_race();
    test_midstream_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
